// File: rtl/multiplexing_pkg.sv
// Shared definitions for the LED multiplexing datapath: sequencer state
// encoding and the default number of multiplexed rows.
package multiplexing_pkg;

  localparam int DEFAULT_NB_MUX_ROWS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_BLANK,
    ST_LATCH,
    ST_ON
  } mux_state_e;

endpackage

// File: rtl/mux_row_sequencer.sv
// Sweeps all multiplexing rows once per start: preload row 0, then per row
// blank -> latch -> lit, streaming the next row's LED words while lit.
module mux_row_sequencer
  import multiplexing_pkg::*;
#(
  parameter int  NB_LEDS_PER_GROUP = 16,
  parameter int  NB_MUX_ROWS       = DEFAULT_NB_MUX_ROWS,
  parameter int  BLANK_CYCLES      = 4,
  parameter int  MIN_ON_CYCLES     = 64,
  localparam int LED_W = (NB_LEDS_PER_GROUP > 1) ? $clog2(NB_LEDS_PER_GROUP) : 1,
  localparam int ROW_W = (NB_MUX_ROWS > 1) ? $clog2(NB_MUX_ROWS) : 1,
  localparam int ON_W  = $clog2(MIN_ON_CYCLES + 1),
  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  output logic [LED_W-1:0]       led,
  output logic                   led_valid,
  input  logic                   led_ready,
  output logic                   latch,
  output logic [NB_MUX_ROWS-1:0] mux_en,
  output logic                   busy,
  output logic                   sweep_done
);

  mux_state_e state_q, state_d;

  logic [LED_W-1:0]       led_q, led_d;
  logic                   led_valid_q, led_valid_d;
  logic                   latch_q, latch_d;
  logic [NB_MUX_ROWS-1:0] mux_en_q, mux_en_d;
  logic                   busy_q, busy_d;
  logic                   sweep_done_q, sweep_done_d;

  logic [ROW_W-1:0] row_q, row_d;
  logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
  logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic             load_done_q, load_done_d;

  logic            xfer;
  logic            last_led;
  logic            last_row;
  logic            blank_end;
  logic            load_complete;
  logic            on_exit;
  logic [ON_W-1:0] on_cnt_inc;

  assign xfer          = led_valid_q & led_ready;
  assign last_led      = (led_q == LED_W'(NB_LEDS_PER_GROUP - 1));
  assign last_row      = (row_q == ROW_W'(NB_MUX_ROWS - 1));
  assign blank_end     = (blank_cnt_q == BLK_W'(BLANK_CYCLES - 1));
  assign on_cnt_inc    = (on_cnt_q >= ON_W'(MIN_ON_CYCLES)) ? on_cnt_q : on_cnt_q + ON_W'(1);
  // The last row has no successor to load; otherwise the final transfer may land on the exit cycle.
  assign load_complete = last_row | load_done_q | (xfer & last_led);
  assign on_exit       = (on_cnt_inc >= ON_W'(MIN_ON_CYCLES)) & load_complete;

  // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_PRELOAD;
      ST_PRELOAD: if (xfer && last_led) state_d = ST_BLANK;
      ST_BLANK:   if (blank_end) state_d = ST_LATCH;
      ST_LATCH:   state_d = ST_ON;
      ST_ON:      if (on_exit) state_d = last_row ? ST_IDLE : ST_BLANK;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they can be registered without a cycle of lag.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    row_d       = row_q;
    on_cnt_d    = on_cnt_q;
    blank_cnt_d = blank_cnt_q;
    load_done_d = load_done_q;
    led_d       = led_q;
    led_valid_d = led_valid_q;

    if (xfer) begin
      led_d = last_led ? '0 : led_q + LED_W'(1);
      if (last_led) begin
        led_valid_d = 1'b0;
        load_done_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d       = '0;
          led_d       = '0;
          led_valid_d = 1'b1;
          load_done_d = 1'b0;
        end
      end
      ST_BLANK: begin
        blank_cnt_d = blank_end ? '0 : blank_cnt_q + BLK_W'(1);
      end
      ST_LATCH: begin
        on_cnt_d    = '0;
        led_d       = '0;
        led_valid_d = !last_row;
        load_done_d = 1'b0;
      end
      ST_ON: begin
        on_cnt_d = on_cnt_inc;
        if (on_exit) begin
          led_valid_d = 1'b0;
          row_d       = last_row ? '0 : row_q + ROW_W'(1);
        end
      end
      default: ;
    endcase

    latch_d      = (state_d == ST_LATCH);
    mux_en_d     = (state_d == ST_ON) ? (NB_MUX_ROWS'(1) << row_d) : '0;
    busy_d       = (state_d != ST_IDLE);
    sweep_done_d = (state_q == ST_ON) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      led_q        <= '0;
      led_valid_q  <= 1'b0;
      latch_q      <= 1'b0;
      mux_en_q     <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      row_q        <= '0;
      on_cnt_q     <= '0;
      blank_cnt_q  <= '0;
      load_done_q  <= 1'b0;
    end else begin
      led_q        <= led_d;
      led_valid_q  <= led_valid_d;
      latch_q      <= latch_d;
      mux_en_q     <= mux_en_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      row_q        <= row_d;
      on_cnt_q     <= on_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      load_done_q  <= load_done_d;
    end
  end

  assign led        = led_q;
  assign led_valid  = led_valid_q;
  assign latch      = latch_q;
  assign mux_en     = mux_en_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule
